// File: rtl/imem_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_pkg
// Description : Shared constants and state encodings for the serial
//               instruction-memory boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_boot_pkg;

  // Frame start marker
  localparam logic [7:0] c_HDR_BYTE = 8'hA5;

  // Frame parser states
  typedef enum logic [2:0] {
    WAIT_HDR = 3'd0,
    CNT_HI   = 3'd1,
    CNT_LO   = 3'd2,
    DATA     = 3'd3,
    CSUM     = 3'd4,
    DONE     = 3'd5
  } frame_state_e;

  // UART receiver states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BITS  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver with input synchronizer, start-bit
//               glitch rejection, mid-bit sampling and stop-bit checking.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import imem_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_pulse_o
);

  localparam int              CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            rx_prev_q;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q;
  logic            frame_err_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit timer and shift register; emits single-cycle valid / error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == c_HALF_LAST) begin
            cnt_q <= '0;
            // A line that is high again at mid start bit was only a glitch
            if (rx_sync_q) begin
              state_q <= IDLE;
            end else begin
              state_q   <= BITS;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BITS: begin
          if (cnt_q == c_BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == c_BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_sync_q) byte_valid_q <= 1'b1;
            else           frame_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_valid_o      = byte_valid_q;
  assign byte_data_o       = shift_q;
  assign frame_err_pulse_o = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : UART boot loader. Parses A5 / count / words / XOR checksum
//               frames, writes words to instruction memory and releases the
//               core reset once a complete image is verified.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  core_rst,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  load_done,
  output logic                  load_err
);

  // Largest word count the memory can hold, in 17 bits to compare with count
  localparam logic [16:0] c_MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk              (clk),
    .rst              (rst),
    .rx_i             (uart_rx),
    .byte_valid_o     (rx_valid),
    .byte_data_o      (rx_data),
    .frame_err_pulse_o(rx_ferr)
  );

  frame_state_e          state_q;
  logic [7:0]            cnt_hi_q;
  logic [15:0]           rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [23:0]           word_q;
  logic [1:0]            byte_idx_q;
  logic [7:0]            csum_q;
  logic                  core_rst_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  load_done_q;
  logic                  load_err_q;

  logic [15:0] count_w;
  assign count_w = {cnt_hi_q, rx_data};

  // Frame parser with registered memory-write and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_HDR;
      cnt_hi_q     <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      core_rst_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      if (rx_valid) begin
        case (state_q)
          WAIT_HDR, DONE: begin
            // Header starts a fresh load; the core is held until it verifies
            if (rx_data == c_HDR_BYTE) begin
              state_q     <= CNT_HI;
              load_err_q  <= 1'b0;
              load_done_q <= 1'b0;
              core_rst_q  <= 1'b1;
              addr_q      <= '0;
              csum_q      <= '0;
              byte_idx_q  <= '0;
            end
          end
          CNT_HI: begin
            cnt_hi_q <= rx_data;
            state_q  <= CNT_LO;
          end
          CNT_LO: begin
            if (count_w == 16'd0) begin
              state_q <= CSUM;
            end else if ({1'b0, count_w} > c_MAX_WORDS) begin
              load_err_q <= 1'b1;
              state_q    <= WAIT_HDR;
            end else begin
              rem_q      <= count_w;
              byte_idx_q <= '0;
              state_q    <= DATA;
            end
          end
          DATA: begin
            word_q     <= {word_q[15:0], rx_data};
            csum_q     <= csum_q ^ rx_data;
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= addr_q;
              imem_wdata_q <= {word_q, rx_data};
              // Wraps to zero after a full-capacity image; no write follows
              addr_q       <= addr_q + 1'b1;
              rem_q        <= rem_q - 16'd1;
              if (rem_q == 16'd1) state_q <= CSUM;
            end
          end
          CSUM: begin
            if (rx_data == csum_q) begin
              state_q     <= DONE;
              core_rst_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              load_err_q <= 1'b1;
              state_q    <= WAIT_HDR;
            end
          end
          default: state_q <= WAIT_HDR;
        endcase
      end else if (rx_ferr && (state_q inside {CNT_HI, CNT_LO, DATA, CSUM})) begin
        // A corrupted byte mid-frame invalidates the whole image
        load_err_q <= 1'b1;
        state_q    <= WAIT_HDR;
      end
    end
  end

  assign core_rst   = core_rst_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
`default_nettype wire
